// File: rtl/scandoubler_framing.sv
// scandoubler_framing: input-side line timing for the line-doubling scandoubler.
// Measures line length and hsync width in input pixels, owns the line-buffer
// write address and bank, and generates the 2x-rate read address, the doubled
// hsync and a line-aligned vsync.
//
// Ports:
//   clk_sys      system clock (single domain)
//   reset        asynchronous, active-high reset
//   pe_in        input pixel enable (1x rate)
//   pe_out       output pixel enable (2x rate)
//   hs_in        input hsync, active high
//   vs_in        input vsync, active high
//   hcnt         write address of the current input pixel
//   line_toggle  write bank; the reader uses ~line_toggle
//   sd_hcnt      read address at the output rate
//   hs_sd        doubled hsync, updates on pe_out
//   vs_sd        vsync re-timed to the input line start
//   locked       line length stable
module scandoubler_framing #(
  parameter int HCNT_WIDTH = 9,
  parameter int MIN_LINE   = 15
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  pe_in,
  input  logic                  pe_out,
  input  logic                  hs_in,
  input  logic                  vs_in,
  output logic [HCNT_WIDTH-1:0] hcnt,
  output logic                  line_toggle,
  output logic [HCNT_WIDTH-1:0] sd_hcnt,
  output logic                  hs_sd,
  output logic                  vs_sd,
  output logic                  locked
);

  localparam logic [HCNT_WIDTH-1:0] HMAX  = '1;
  localparam logic [HCNT_WIDTH-1:0] MIN_L = HCNT_WIDTH'(MIN_LINE);

  logic                  hs_prev_q,      hs_prev_d;
  logic [HCNT_WIDTH-1:0] hcnt_q,         hcnt_d;
  logic [HCNT_WIDTH-1:0] hs_max_q,       hs_max_d;
  logic [HCNT_WIDTH-1:0] hs_width_q,     hs_width_d;
  logic                  line_toggle_q,  line_toggle_d;
  logic                  vs_sd_q,        vs_sd_d;
  logic                  restart_pend_q, restart_pend_d;
  logic [HCNT_WIDTH-1:0] sd_hcnt_q,      sd_hcnt_d;
  logic                  hs_sd_q,        hs_sd_d;
  logic                  locked_q,       locked_d;
  logic [1:0]            rise_cnt_q,     rise_cnt_d;

  logic                  rise;
  logic                  fall;
  logic                  hcnt_sat;
  logic [HCNT_WIDTH-1:0] hcnt_inc;
  logic [HCNT_WIDTH-1:0] sd_next;

  always_comb begin
    rise     = pe_in & hs_in & ~hs_prev_q;
    fall     = pe_in & ~hs_in & hs_prev_q;
    hcnt_sat = (hcnt_q == HMAX);
    hcnt_inc = hcnt_sat ? hcnt_q : hcnt_q + 1'b1;

    hs_prev_d      = hs_prev_q;
    hcnt_d         = hcnt_q;
    hs_max_d       = hs_max_q;
    hs_width_d     = hs_width_q;
    line_toggle_d  = line_toggle_q;
    vs_sd_d        = vs_sd_q;
    restart_pend_d = restart_pend_q;
    sd_hcnt_d      = sd_hcnt_q;
    hs_sd_d        = hs_sd_q;
    locked_d       = locked_q;
    rise_cnt_d     = rise_cnt_q;

    // Restart beats wrap; both land on 0.
    if (restart_pend_q)
      sd_next = '0;
    else if (sd_hcnt_q == hs_max_q)
      sd_next = '0;
    else
      sd_next = sd_hcnt_q + 1'b1;

    // Output side runs first so a rise in the same cycle re-arms the
    // restart for the following pe_out.
    if (pe_out) begin
      sd_hcnt_d      = sd_next;
      hs_sd_d        = (sd_next < hs_width_q);
      restart_pend_d = 1'b0;
    end

    if (pe_in)
      hs_prev_d = hs_in;

    if (rise) begin
      hs_max_d       = hcnt_q;
      hcnt_d         = '0;
      line_toggle_d  = ~line_toggle_q;
      vs_sd_d        = vs_in;
      restart_pend_d = 1'b1;
      // The first two measurements after reset are partial lines and
      // must not be trusted for lock.
      locked_d       = (rise_cnt_q == 2'd2) &&
                       (hcnt_q == hs_max_q) &&
                       (hcnt_q >= MIN_L);
      if (rise_cnt_q != 2'd2)
        rise_cnt_d = rise_cnt_q + 2'd1;
    end else if (pe_in) begin
      hcnt_d = hcnt_inc;
    end

    if (fall)
      hs_width_d = hcnt_inc;

    // A full buffer without hsync means the source is gone.
    if (hcnt_sat)
      locked_d = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_prev_q      <= 1'b0;
      hcnt_q         <= '0;
      hs_max_q       <= '1;
      hs_width_q     <= '0;
      line_toggle_q  <= 1'b0;
      vs_sd_q        <= 1'b0;
      restart_pend_q <= 1'b0;
      sd_hcnt_q      <= '0;
      hs_sd_q        <= 1'b0;
      locked_q       <= 1'b0;
      rise_cnt_q     <= 2'd0;
    end else begin
      hs_prev_q      <= hs_prev_d;
      hcnt_q         <= hcnt_d;
      hs_max_q       <= hs_max_d;
      hs_width_q     <= hs_width_d;
      line_toggle_q  <= line_toggle_d;
      vs_sd_q        <= vs_sd_d;
      restart_pend_q <= restart_pend_d;
      sd_hcnt_q      <= sd_hcnt_d;
      hs_sd_q        <= hs_sd_d;
      locked_q       <= locked_d;
      rise_cnt_q     <= rise_cnt_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign line_toggle = line_toggle_q;
  assign sd_hcnt     = sd_hcnt_q;
  assign hs_sd       = hs_sd_q;
  assign vs_sd       = vs_sd_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_scandoubler_framing.sv
// tb_scandoubler_framing: directed scoreboard bench for scandoubler_framing.
// Stimulus queues expected values; a monitor compares them off the clock edge.
module tb_scandoubler_framing;

  localparam int W = 9;

  logic         clk_sys = 1'b0;
  logic         reset   = 1'b0;
  logic         pe_in   = 1'b0;
  logic         pe_out  = 1'b0;
  logic         hs_in   = 1'b0;
  logic         vs_in   = 1'b0;
  logic [W-1:0] hcnt;
  logic [W-1:0] sd_hcnt;
  logic         line_toggle;
  logic         hs_sd;
  logic         vs_sd;
  logic         locked;

  scandoubler_framing #(
    .HCNT_WIDTH(W),
    .MIN_LINE  (15)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pe_in      (pe_in),
    .pe_out     (pe_out),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .hcnt       (hcnt),
    .line_toggle(line_toggle),
    .sd_hcnt    (sd_hcnt),
    .hs_sd      (hs_sd),
    .vs_sd      (vs_sd),
    .locked     (locked)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;
  int q_sig[$];
  int q_exp[$];
  bit exp_tog = 1'b0;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      0:       return 32'(hcnt);
      1:       return 32'(line_toggle);
      2:       return 32'(sd_hcnt);
      3:       return 32'(hs_sd);
      4:       return 32'(vs_sd);
      default: return 32'(locked);
    endcase
  endfunction

  function automatic string sname(input int sig);
    case (sig)
      0:       return "hcnt";
      1:       return "line_toggle";
      2:       return "sd_hcnt";
      3:       return "hs_sd";
      4:       return "vs_sd";
      default: return "locked";
    endcase
  endfunction

  task automatic expect_sig(input int sig, input int v);
    q_sig.push_back(sig);
    q_exp.push_back(v);
  endtask

  // Monitor: outputs are stable between edges; compare just after the
  // falling edge, or just after an asynchronous reset assertion.
  initial begin
    int s;
    int e;
    logic [31:0] a;
    forever begin
      @(negedge clk_sys or posedge reset);
      #1;
      while (q_sig.size() > 0) begin
        s = q_sig.pop_front();
        e = q_exp.pop_front();
        a = actual(s);
        n_tests++;
        if (a !== 32'(e)) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d at %0t",
                   sname(s), a, e, $time);
        end
      end
    end
  end

  task automatic cyc(input logic pi, input logic po);
    pe_in  = pi;
    pe_out = po;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_sd(input int v, input int w);
    expect_sig(2, v);
    expect_sig(3, int'(v < w));
  endtask

  // One input line of len pixels, hsync 8 pixels, 4 clocks per pixel.
  // m: modulus of sd_hcnt during this line (previous line length), 0 skips.
  // coinc: pe_out on clocks 0/2 (with pe_in) instead of 1/3.
  task automatic line(input int len, input int m, input int lk,
                      input int vs_start, input int exp_vs,
                      input bit coinc, input int first_sd,
                      input int hsw_prev);
    int w;
    for (int p = 0; p < len; p++) begin
      hs_in = (p < 8);
      vs_in = (p >= vs_start);
      cyc(1'b1, coinc);
      if (p == 0) exp_tog = ~exp_tog;
      expect_sig(0, (p > 511) ? 511 : p);
      expect_sig(1, int'(exp_tog));
      expect_sig(5, (p >= 512) ? 0 : lk);
      expect_sig(4, exp_vs);
      w = (p <= 8) ? hsw_prev : 8;
      if (coinc && m > 0 && (p > 0 || first_sd >= 0))
        chk_sd((p == 0) ? first_sd : (2*p-1) % m, w);
      w = (p < 8) ? hsw_prev : 8;
      cyc(1'b0, !coinc);
      if (m > 0) begin
        if (!coinc)
          chk_sd((2*p) % m, w);
        else if (p > 0 || first_sd >= 0)
          chk_sd((p == 0) ? first_sd : (2*p-1) % m, w);
      end
      cyc(1'b0, coinc);
      if (m > 0) chk_sd((2*p) % m, w);
      cyc(1'b0, !coinc);
      if (m > 0) chk_sd(coinc ? (2*p) % m : (2*p+1) % m, w);
    end
  endtask

  task automatic expect_reset_vals();
    expect_sig(0, 0);
    expect_sig(1, 0);
    expect_sig(2, 0);
    expect_sig(3, 0);
    expect_sig(4, 0);
    expect_sig(5, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (5) cyc(1'b0, 1'b0);
    expect_reset_vals();
    cyc(1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b0);
    expect_reset_vals();

    // Steady 100-pixel lines, then 100 -> 120 length change.
    line(100,   0, 0, 1000, 0, 1'b0, -1, 0);
    line(100, 100, 0, 1000, 0, 1'b0, -1, 8);
    line(100, 100, 1, 1000, 0, 1'b0, -1, 8);
    line(100, 100, 1, 1000, 0, 1'b0, -1, 8);
    line(120, 100, 1, 1000, 0, 1'b0, -1, 8);
    line(120, 120, 0, 1000, 0, 1'b0, -1, 8);
    line(120, 120, 1, 1000, 0, 1'b0, -1, 8);

    // No hsync for 520 pixels: hcnt saturates, lock lost.
    line(520,   0, 1, 1000, 0, 1'b0, -1, 8);
    line(120, 512, 0, 1000, 0, 1'b0, -1, 8);
    line(100, 120, 0, 1000, 0, 1'b0, -1, 8);
    line(100, 100, 0, 1000, 0, 1'b0, -1, 8);
    line(100, 100, 1, 1000, 0, 1'b0, -1, 8);

    // vsync rising mid-line appears only at the next line start.
    line(100, 100, 1,   40, 0, 1'b0, -1, 8);
    line(100, 100, 1,    0, 1, 1'b0, -1, 8);
    line(100, 100, 1, 1000, 0, 1'b0, -1, 8);

    // Coincident pe_in/pe_out; second line also hits wrap with restart.
    line(100, 100, 1, 1000, 0, 1'b1,  0, 8);
    line(100, 100, 1, 1000, 0, 1'b1, 99, 8);

    // Asynchronous reset at hcnt = 50, between clock edges.
    line(50, 100, 1, 1000, 0, 1'b0, -1, 8);
    hs_in = 1'b0;
    cyc(1'b1, 1'b0);
    expect_sig(0, 50);
    @(negedge clk_sys);
    #2;
    reset  = 1'b1;
    pe_in  = 1'b0;
    pe_out = 1'b0;
    exp_tog = 1'b0;
    expect_reset_vals();
    repeat (3) cyc(1'b0, 1'b0);
    reset = 1'b0;
    for (int p = 0; p < 30; p++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
    end
    line(100,  31, 0, 1000, 0, 1'b0, -1, 0);
    line(100, 100, 0, 1000, 0, 1'b0, -1, 8);
    line(100, 100, 1, 1000, 0, 1'b0, -1, 8);

    cyc(1'b0, 1'b0);
    @(negedge clk_sys);
    #3;
    if (q_sig.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0",
               q_sig.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
